// File: rtl/frequency_generator_if.sv
// Control and status bundle for frequency_generator.
//   enable      : level, permits generation
//   start       : one-cycle request to begin output
//   half_period : requested half-period in clk cycles
//   period_load : captures half_period when high
//   burst_len   : rising edges per burst, 0 = continuous
//   signal      : generated square wave
//   busy        : generator is not idle
//   done        : one-cycle pulse at burst completion
//   edge_count  : rising edges generated since start
//   dbg_state   : current FSM state (IDLE=0, HIGH=1, LOW=2)
interface frequency_generator_if;
  logic        enable;
  logic        start;
  logic [11:0] half_period;
  logic        period_load;
  logic [6:0]  burst_len;
  logic        signal;
  logic        busy;
  logic        done;
  logic [6:0]  edge_count;
  logic [1:0]  dbg_state;

  modport master (
    output enable, start, half_period, period_load, burst_len,
    input  signal, busy, done, edge_count, dbg_state
  );

  modport slave (
    input  enable, start, half_period, period_load, burst_len,
    output signal, busy, done, edge_count, dbg_state
  );
endinterface

// File: rtl/frequency_generator.sv
// Programmable square-wave generator with burst and continuous modes.
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   reset : asynchronous, active-high
//   bus   : frequency_generator_if.slave (controls in, registered status out)
// Each phase (HIGH or LOW) lasts hp clk cycles. A new half-period may be loaded
// at any time; it takes effect only at a phase boundary so no phase is cut short.
module frequency_generator #(
  parameter logic [11:0] DEFAULT_HALF_PERIOD = 12'd50
) (
  input logic                  clk,
  input logic                  reset,
  frequency_generator_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

  state_e      state_q;
  logic        signal_q;
  logic        busy_q;
  logic        done_q;
  logic [6:0]  edge_count_q;
  logic [6:0]  burst_q;
  logic [11:0] cnt_q;
  logic [11:0] pending_q;
  logic [11:0] hp_q;

  logic [11:0] load_val;
  logic [11:0] next_hp;

  // A zero half-period is meaningless; clamp it to one cycle. next_hp is the
  // value hp takes when it is refreshed this cycle, so a load that lands on a
  // phase boundary already governs the following phase.
  always_comb begin
    load_val = (bus.half_period == 12'd0) ? 12'd1 : bus.half_period;
    next_hp  = bus.period_load ? load_val : pending_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      signal_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      edge_count_q <= 7'd0;
      burst_q      <= 7'd0;
      cnt_q        <= 12'd0;
      pending_q    <= DEFAULT_HALF_PERIOD;
      hp_q         <= DEFAULT_HALF_PERIOD;
    end else begin
      done_q <= 1'b0;
      if (bus.period_load) begin
        pending_q <= load_val;
      end

      case (state_q)
        StIdle: begin
          hp_q     <= next_hp;
          signal_q <= 1'b0;
          busy_q   <= 1'b0;
          cnt_q    <= 12'd0;
          if (bus.start && bus.enable) begin
            state_q      <= StHigh;
            signal_q     <= 1'b1;
            busy_q       <= 1'b1;
            edge_count_q <= 7'd1;
            cnt_q        <= hp_q - 12'd1;
            burst_q      <= bus.burst_len;
          end
        end

        StHigh: begin
          if (cnt_q == 12'd0) begin
            state_q  <= StLow;
            signal_q <= 1'b0;
            hp_q     <= next_hp;
            cnt_q    <= next_hp - 12'd1;
          end else begin
            cnt_q <= cnt_q - 12'd1;
          end
        end

        StLow: begin
          if (cnt_q == 12'd0) begin
            hp_q <= next_hp;
            if ((burst_q != 7'd0) && (edge_count_q == burst_q)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= 12'd0;
            end else if (!bus.enable) begin
              // enable is only honoured here, after a full LOW phase
              state_q <= StIdle;
              busy_q  <= 1'b0;
              cnt_q   <= 12'd0;
            end else begin
              state_q      <= StHigh;
              signal_q     <= 1'b1;
              edge_count_q <= edge_count_q + 7'd1;  // wraps 127 -> 0
              cnt_q        <= next_hp - 12'd1;
            end
          end else begin
            cnt_q <= cnt_q - 12'd1;
          end
        end

        default: begin
          // unused encoding 3: recover to idle
          state_q  <= StIdle;
          signal_q <= 1'b0;
          busy_q   <= 1'b0;
          cnt_q    <= 12'd0;
        end
      endcase
    end
  end

  assign bus.signal     = signal_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.edge_count = edge_count_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/frequency_generator.md
FREQUENCY_GENERATOR -- requirements
Module: frequency_generator

Interface
REQ-001 SHALL have parameter DEFAULT_HALF_PERIOD, default 12'd50, half-period in clk cycles loaded at reset.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  level; high permits generation.
REQ-005 SHALL have port start  input  1  one-cycle request to begin output.
REQ-006 SHALL have port half_period  input  12  requested half-period in clk cycles.
REQ-007 SHALL have port period_load  input  1  captures half_period when high.
REQ-008 SHALL have port burst_len  input  7  rising edges per burst; 0 = continuous.
REQ-009 SHALL have port signal  output  1  generated square wave, registered.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on burst completion.
REQ-012 SHALL have port edge_count  output  7  rising edges generated since start.
REQ-013 SHALL have port dbg_state  output  2  state encoding: IDLE=0, HIGH=1, LOW=2.

Function
REQ-014 SHALL hold a pending half-period register, reset to DEFAULT_HALF_PERIOD, written from half_period on any cycle with period_load=1; a value of 0 SHALL be stored as 1.
REQ-015 SHALL use an active half-period register (hp) for all phase timing, copied from pending:
- in IDLE, every cycle;
- in HIGH/LOW, only at a phase toggle.
- If period_load coincides with a toggle, the newly loaded value SHALL be used for the next phase.
REQ-016 SHALL implement states IDLE, HIGH, LOW; encoding 3 SHALL return to IDLE on the next clock.
REQ-017 IDLE: signal=0, busy=0. On start=1 with enable=1, SHALL enter HIGH next cycle:
- signal=1, edge_count=1;
- phase counter loaded with hp-1;
- burst_len latched.
REQ-018 start SHALL be ignored when enable=0 or busy=1.
REQ-019 HIGH: counter SHALL decrement each cycle; at 0, SHALL enter LOW with signal=0 and counter reloaded with hp-1. Each phase therefore lasts exactly hp cycles; period = 2*hp.
REQ-020 LOW: at counter 0 SHALL go to:
- IDLE with done=1 for one cycle, if latched burst_len!=0 and edge_count==burst_len;
- IDLE without done, if enable=0;
- otherwise HIGH with signal=1, edge_count+1 (wraps 127->0), counter reloaded with hp-1.
REQ-021 enable deassertion SHALL never truncate a phase; the current HIGH and LOW phases complete before IDLE.
REQ-022 SHALL keep edge_count holding its last value in IDLE; it is cleared only by reset or a new start.
REQ-023 In continuous mode (burst_len=0), SHALL run until enable=0, never pulsing done.
REQ-024 hp=1 SHALL give a square wave of period 2 clk cycles with no idle gaps.
REQ-025 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-026 While reset=1, SHALL hold: state=IDLE, signal=0, busy=0, done=0, edge_count=0, dbg_state=0, counter=0, pending=hp=DEFAULT_HALF_PERIOD.
REQ-027 Reset asserted mid-phase SHALL force all of REQ-026 immediately; on release, SHALL require a fresh start.

Verification
REQ-028 SHALL verify default burst: after reset, enable=1, burst_len=3, start pulse -> 3 pulses, each 50 high / 50 low; done at end of third LOW; edge_count=3; busy low after.
REQ-029 SHALL verify minimum period: period_load with half_period=0, burst_len=0, start -> signal toggles every cycle (period 2); enable=0 -> stops after a completed LOW.
REQ-030 SHALL verify glitch-free reload: running at hp=10, period_load hp=4 mid-HIGH -> current HIGH lasts 10 cycles; following LOW lasts 4.
REQ-031 SHALL verify ignored starts: start during busy -> no restart and edge_count unaffected; start with enable=0 -> stays IDLE.
REQ-032 SHALL verify edge_count wrap: hp=1, burst_len=0, 130 pulses -> edge_count reads 2, no done.
REQ-033 SHALL verify async reset: reset asserted mid-HIGH, between clock edges -> signal=0, busy=0, dbg_state=0 before the next clk edge.
